// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send and
// clocks one command byte out to the keyboard on device-generated falling edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 425600,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       CLK28,
  input  logic       sreset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(FILTER_CYCLES) + 1;

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    ACK,
    RELEASE
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [WW-1:0] wdog, wdog_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [9:0]    shreg, shreg_n;
  logic          ack_bad, ack_bad_n;
  logic          busy_n, done_n, error_n, clk_oe_n, dat_oe_n;
  logic          wd_active;

  // Sync registers idle high so the bus looks released straight out of reset;
  // a new clock level is only taken after FILTER_CYCLES agreeing samples.
  always_ff @(posedge CLK28) begin
    if (sreset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt_cnt  <= '0;
        clk_filt <= clk_sync[1];
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK28) begin
    if (sreset) begin
      state      <= IDLE;
      inh_cnt    <= '0;
      wdog       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      ack_bad    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_n;
      inh_cnt    <= inh_cnt_n;
      wdog       <= wdog_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      ack_bad    <= ack_bad_n;
      busy       <= busy_n;
      tx_done    <= done_n;
      tx_error   <= error_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
    end
  end

  assign wd_active = (state == RTS) || (state == DATA) ||
                     (state == ACK) || (state == RELEASE);

  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    wdog_n    = wdog;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    ack_bad_n = ack_bad;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = 1'b0;
    clk_oe_n  = ps2_clk_oe;
    dat_oe_n  = ps2_dat_oe;

    if (wd_active) begin
      wdog_n = wdog + 1'b1;
    end

    case (state)
      IDLE: begin
        // The cycle carrying a done/error pulse must not start a new frame.
        if (tx_start && !tx_done && !tx_error) begin
          state_n   = INHIBIT;
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
          dat_oe_n  = 1'b0;
          inh_cnt_n = '0;
          shreg_n   = {1'b1, ~^tx_data, tx_data};
        end
      end

      INHIBIT: begin
        inh_cnt_n = inh_cnt + 1'b1;
        if (inh_cnt == INH_PRE) begin
          dat_oe_n = 1'b1;
        end
        if (inh_cnt == INH_LAST) begin
          state_n  = RTS;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          wdog_n   = '0;
          bitcnt_n = '0;
        end
      end

      // shreg shifts right so bit 0 is always the next bit to present.
      RTS, DATA: begin
        if (fall) begin
          dat_oe_n = ~shreg[0];
          shreg_n  = {1'b1, shreg[9:1]};
          bitcnt_n = bitcnt + 1'b1;
          state_n  = (bitcnt == 4'd9) ? ACK : DATA;
        end
      end

      ACK: begin
        if (fall) begin
          ack_bad_n = dat_sync[1];
          state_n   = RELEASE;
        end
      end

      RELEASE: begin
        if (clk_sync[1] && dat_sync[1]) begin
          done_n   = ~ack_bad;
          error_n  = ack_bad;
          busy_n   = 1'b0;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (wd_active && (wdog == WD_LAST)) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
      error_n  = 1'b1;
      busy_n   = 1'b0;
      state_n  = IDLE;
    end
  end

  assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the
// host; expected frames are queued at stimulus time and popped on capture.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 5000;
  localparam int HALF = 40;

  logic       CLK28 = 1'b0;
  logic       sreset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_bad = 0;

  logic [9:0] exp_q[$];
  logic [9:0] bits;
  logic [9:0] exp_frame;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_CYCLES (8)
  ) dut (
    .CLK28     (CLK28),
    .sreset    (sreset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_inhibit(rx_inhibit)
  );

  always #5 CLK28 = ~CLK28;

  always @(negedge CLK28) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if ((tx_done || tx_error) && busy) busy_bad++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge CLK28);
    tx_data  = d;
    tx_start = 1'b1;
    exp_q.push_back({1'b1, ~^d, d});
    @(negedge CLK28);
    tx_start = 1'b0;
  endtask

  // Counts host clock-low cycles, starting with the current sample, and
  // returns on the first cycle of request-to-send.
  task automatic measureInhibit();
    int low = 0;
    int both = 0;
    for (int k = 0; k < 4 * INH; k++) begin
      if (ps2_clk_oe) begin
        low++;
        if (ps2_dat_oe) both++;
      end else if (low > 0) begin
        break;
      end
      @(negedge CLK28);
    end
    checkOutput("inhibit_long_enough", (low >= INH) ? 1 : 0, 1);
    checkOutput("dat_low_one_cycle_early", both, 1);
    checkOutput("rts_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  task automatic deviceRun(input bit do_ack, input int nfalls, input bit glitch,
                           output logic [9:0] got_bits);
    got_bits = '0;
    repeat (30) @(negedge CLK28);
    checkOutput("start_bit", ps2_dat_in, 0);
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10 && do_ack) begin
        dev_dat_low = 1'b1;
        repeat (5) @(negedge CLK28);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLK28);
      if (i < 10) got_bits[i] = ps2_dat_in;
      if (i == nfalls - 1 && nfalls < 11) return;
      dev_clk_low = 1'b0;
      if (glitch && i == 3) begin
        repeat (HALF / 2) @(negedge CLK28);
        dev_clk_low = 1'b1;
        repeat (2) @(negedge CLK28);
        dev_clk_low = 1'b0;
        repeat (HALF / 2 - 2) @(negedge CLK28);
      end else begin
        repeat (HALF) @(negedge CLK28);
      end
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic waitPulse(input int base);
    bit got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt + err_cnt != base) begin
        got = 1'b1;
        break;
      end
      @(negedge CLK28);
    end
    checkOutput("pulse_seen", got, 1);
  endtask

  task automatic runFrame(input logic [7:0] d, input bit ack);
    int d0 = done_cnt;
    int e0 = err_cnt;
    applyStimulus(d);
    checkOutput("busy_set", busy, 1);
    checkOutput("rx_inhibit_set", rx_inhibit, 1);
    measureInhibit();
    deviceRun(ack, 11, 1'b0, bits);
    exp_frame = exp_q.pop_front();
    checkOutput("frame_bits", bits, exp_frame);
    waitPulse(d0 + e0);
    @(negedge CLK28);
    checkOutput("done_count", done_cnt - d0, ack ? 1 : 0);
    checkOutput("error_count", err_cnt - e0, ack ? 0 : 1);
    checkOutput("idle_after", {busy, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    int d0, e0, k;
    bit got;

    $display("[TB] start");
    repeat (5) @(negedge CLK28);
    sreset = 1'b0;
    @(negedge CLK28);
    checkOutput("reset_outputs",
                {busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe, rx_inhibit}, 0);

    runFrame(8'hED, 1'b1);
    runFrame(8'h07, 1'b1);

    // tx_start held high across a whole frame: ignored while busy and in the
    // pulse cycle, then accepted; that second frame is left to time out.
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'h00);
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    measureInhibit();
    deviceRun(1'b1, 11, 1'b0, bits);
    exp_frame = exp_q.pop_front();
    checkOutput("frame_bits_held", bits, exp_frame);
    got = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge CLK28);
      if (tx_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("held_pulse", got, 1);
    @(negedge CLK28);
    checkOutput("start_in_pulse_ignored", busy, 0);
    @(negedge CLK28);
    checkOutput("start_next_accepted", busy, 1);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    measureInhibit();
    for (k = 1; k <= 2 * TMO; k++) begin
      @(negedge CLK28);
      if (tx_error) break;
    end
    checkOutput("timeout_cycles", k, TMO);
    checkOutput("timeout_lines", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    @(negedge CLK28);
    checkOutput("timeout_done_count", done_cnt - d0, 1);
    checkOutput("timeout_error_count", err_cnt - e0, 1);

    runFrame(8'h3C, 1'b0);

    // Reset while the device holds the clock low during the 5th data bit.
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hA5);
    measureInhibit();
    deviceRun(1'b1, 5, 1'b0, bits);
    exp_frame = exp_q.pop_front();
    sreset = 1'b1;
    @(negedge CLK28);
    checkOutput("reset_mid_frame", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    sreset = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (200) @(negedge CLK28);
    checkOutput("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    runFrame(8'hFF, 1'b1);

    // Stray tx_start pulses with other data, plus a 2-cycle clock glitch.
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'h96);
    fork
      begin
        measureInhibit();
        deviceRun(1'b1, 11, 1'b1, bits);
      end
      begin
        repeat (20) @(negedge CLK28);
        tx_data  = 8'h11;
        tx_start = 1'b1;
        @(negedge CLK28);
        tx_start = 1'b0;
        repeat (400) @(negedge CLK28);
        tx_data  = 8'hFE;
        tx_start = 1'b1;
        @(negedge CLK28);
        tx_start = 1'b0;
        repeat (300) @(negedge CLK28);
        tx_start = 1'b1;
        @(negedge CLK28);
        tx_start = 1'b0;
      end
    join
    exp_frame = exp_q.pop_front();
    checkOutput("frame_bits_glitch", bits, exp_frame);
    waitPulse(d0 + e0);
    @(negedge CLK28);
    checkOutput("glitch_done_count", done_cnt - d0, 1);
    checkOutput("glitch_error_count", err_cnt - e0, 0);
    repeat (50) @(negedge CLK28);
    checkOutput("no_queued_start", busy, 0);

    checkOutput("pulse_with_busy", busy_bad, 0);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
